// File: rtl/tsip_pkg.sv
// Shared constants and state encoding for the TSIP Primary Timing decoder.
package tsip_pkg;

  localparam logic [7:0] DLE               = 8'h10;
  localparam logic [7:0] ETX               = 8'h03;
  localparam logic [7:0] ID_PRIMARY_TIMING = 8'h8F;
  localparam logic [7:0] SUB_TIMING        = 8'hAB;

  // Payload counter saturates one past the expected length to flag over-length frames.
  localparam logic [4:0] PAYLOAD_LEN = 5'd17;
  localparam logic [4:0] CNT_SAT     = 5'd18;

  localparam logic [4:0] OFS_SUB    = 5'd0;
  localparam logic [4:0] OFS_FLAGS  = 5'd9;
  localparam logic [4:0] OFS_SEC    = 5'd10;
  localparam logic [4:0] OFS_MIN    = 5'd11;
  localparam logic [4:0] OFS_HOUR   = 5'd12;
  localparam logic [4:0] OFS_DAY    = 5'd13;
  localparam logic [4:0] OFS_MONTH  = 5'd14;
  localparam logic [4:0] OFS_YEAR_H = 5'd15;
  localparam logic [4:0] OFS_YEAR_L = 5'd16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ID   = 2'd1,
    DATA     = 2'd2,
    DATA_DLE = 2'd3
  } state_t;

endpackage

// File: rtl/tsip_timing_decoder_deframer.sv
// TSIP deframer: DLE/ETX framing, DLE unstuffing, packet ID latch and inter-byte timeout.
// Event outputs are decoded from the current byte so the top can act on the same edge.
module tsip_deframer
  import tsip_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  output logic       byte_dv,
  output logic [7:0] data_byte,
  output logic [7:0] id,
  output logic       sof,
  output logic       eof,
  output logic       abort
);

  localparam bit          TMO_EN   = (TIMEOUT_CLKS != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CLKS) - 32'd1;

  state_t      state;
  logic [7:0]  cur_id;
  logic [31:0] tmo_cnt;
  logic        tmo_hit;

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign tmo_hit = TMO_EN && (state != IDLE) && !rx_dv && (tmo_cnt == TMO_LAST);

  always_comb begin
    byte_dv   = 1'b0;
    sof       = 1'b0;
    eof       = 1'b0;
    abort     = 1'b0;
    data_byte = rx_byte;
    id        = cur_id;
    if (rx_dv) begin
      case (state)
        IDLE: begin
          sof = 1'b0;
        end
        GET_ID: begin
          if (rx_byte != DLE && rx_byte != ETX) begin
            sof = 1'b1;
          end else begin
            sof = 1'b0;
          end
        end
        DATA: begin
          if (rx_byte != DLE) begin
            byte_dv = 1'b1;
          end else begin
            byte_dv = 1'b0;
          end
        end
        DATA_DLE: begin
          if (rx_byte == DLE) begin
            byte_dv = 1'b1;
          end else if (rx_byte == ETX) begin
            eof = 1'b1;
          end else begin
            eof   = 1'b1;
            abort = 1'b1;
            sof   = 1'b1;
          end
        end
        default: begin
          abort = 1'b0;
        end
      endcase
    end else if (tmo_hit) begin
      eof   = 1'b1;
      abort = 1'b1;
    end else begin
      eof = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur_id  <= 8'h00;
      tmo_cnt <= 32'd0;
    end else begin
      if (rx_dv || state == IDLE || tmo_hit) begin
        tmo_cnt <= 32'd0;
      end else begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end

      if (rx_dv) begin
        case (state)
          IDLE: begin
            // Clear the stale ID so a timeout before the ID byte is not misattributed.
            if (rx_byte == DLE) begin
              state  <= GET_ID;
              cur_id <= 8'h00;
            end
          end
          GET_ID: begin
            if (rx_byte == DLE || rx_byte == ETX) begin
              state <= IDLE;
            end else begin
              state  <= DATA;
              cur_id <= rx_byte;
            end
          end
          DATA: begin
            if (rx_byte == DLE) begin
              state <= DATA_DLE;
            end
          end
          DATA_DLE: begin
            if (rx_byte == DLE) begin
              state <= DATA;
            end else if (rx_byte == ETX) begin
              state <= IDLE;
            end else begin
              state  <= DATA;
              cur_id <= rx_byte;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end else if (tmo_hit) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: rtl/tsip_timing_decoder.sv
// Thunderbolt TSIP Primary Timing (0x8F-AB) decoder driving the thunder_* time-of-day interface.
// Optional macro TSIP_DEC_STATS_EN adds good/error frame counters.
module tsip_timing_decoder
  import tsip_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_thunder_packet_dv,
  output logic [15:0] o_thunder_year,
  output logic [7:0]  o_thunder_month,
  output logic [7:0]  o_thunder_day,
  output logic [7:0]  o_thunder_hour,
  output logic [7:0]  o_thunder_minutes,
  output logic [7:0]  o_thunder_seconds,
  output logic [7:0]  o_thunder_flags,
  output logic        o_frame_err
`ifdef TSIP_DEC_STATS_EN
  ,
  output logic [7:0]  o_good_count,
  output logic [7:0]  o_err_count
`endif
);

  logic       byte_dv;
  logic       sof;
  logic       eof;
  logic       abort;
  logic [7:0] data_byte;
  logic [7:0] id;

  logic [4:0] cnt;
  logic [7:0] sh_sub, sh_flags, sh_sec, sh_min, sh_hour, sh_day, sh_month, sh_year_h, sh_year_l;
  logic       is_timing;
  logic       frame_ok;

  tsip_deframer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_deframer (
    .clk       (i_clk),
    .rst       (i_rst),
    .rx_dv     (i_rx_dv),
    .rx_byte   (i_rx_byte),
    .byte_dv   (byte_dv),
    .data_byte (data_byte),
    .id        (id),
    .sof       (sof),
    .eof       (eof),
    .abort     (abort)
  );

  assign is_timing = (id == ID_PRIMARY_TIMING);
  assign frame_ok  = eof && !abort && is_timing && (sh_sub == SUB_TIMING) && (cnt == PAYLOAD_LEN);

  // Shadow registers fill while the frame streams in; outputs only change on a validated ETX.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= 5'd0;
      sh_sub    <= 8'h00;
      sh_flags  <= 8'h00;
      sh_sec    <= 8'h00;
      sh_min    <= 8'h00;
      sh_hour   <= 8'h00;
      sh_day    <= 8'h00;
      sh_month  <= 8'h00;
      sh_year_h <= 8'h00;
      sh_year_l <= 8'h00;
    end else begin
      if (sof) begin
        cnt <= 5'd0;
      end else if (byte_dv && cnt != CNT_SAT) begin
        cnt <= cnt + 5'd1;
      end

      if (byte_dv && is_timing && cnt < PAYLOAD_LEN) begin
        case (cnt)
          OFS_SUB:    sh_sub    <= data_byte;
          OFS_FLAGS:  sh_flags  <= data_byte;
          OFS_SEC:    sh_sec    <= data_byte;
          OFS_MIN:    sh_min    <= data_byte;
          OFS_HOUR:   sh_hour   <= data_byte;
          OFS_DAY:    sh_day    <= data_byte;
          OFS_MONTH:  sh_month  <= data_byte;
          OFS_YEAR_H: sh_year_h <= data_byte;
          OFS_YEAR_L: sh_year_l <= data_byte;
          default:    sh_sub    <= sh_sub;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_thunder_packet_dv <= 1'b0;
      o_frame_err         <= 1'b0;
      o_thunder_year      <= 16'h0000;
      o_thunder_month     <= 8'h00;
      o_thunder_day       <= 8'h00;
      o_thunder_hour      <= 8'h00;
      o_thunder_minutes   <= 8'h00;
      o_thunder_seconds   <= 8'h00;
      o_thunder_flags     <= 8'h00;
`ifdef TSIP_DEC_STATS_EN
      o_good_count        <= 8'h00;
      o_err_count         <= 8'h00;
`endif
    end else begin
      o_thunder_packet_dv <= 1'b0;
      o_frame_err         <= 1'b0;
      if (frame_ok) begin
        o_thunder_packet_dv <= 1'b1;
        o_thunder_year      <= {sh_year_h, sh_year_l};
        o_thunder_month     <= sh_month;
        o_thunder_day       <= sh_day;
        o_thunder_hour      <= sh_hour;
        o_thunder_minutes   <= sh_min;
        o_thunder_seconds   <= sh_sec;
        o_thunder_flags     <= sh_flags;
`ifdef TSIP_DEC_STATS_EN
        o_good_count        <= o_good_count + 8'd1;
`endif
      end else if (eof && is_timing) begin
        // Covers bad ETX-terminated frames, resync aborts and timeouts alike.
        o_frame_err <= 1'b1;
`ifdef TSIP_DEC_STATS_EN
        o_err_count <= o_err_count + 8'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_tsip_timing_decoder.sv
// Self-checking bench for tsip_timing_decoder: directed frames plus randomized payloads
// checked against a payload-level model of the Primary Timing packet.
module tb_tsip_timing_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        dv, err;
  logic [15:0] year;
  logic [7:0]  month, day, hour, minutes, seconds, flags;
`ifdef TSIP_DEC_STATS_EN
  logic [7:0]  good_count, err_count;
`endif

  always #5 clk = ~clk;

  tsip_timing_decoder #(.TIMEOUT_CLKS(50)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_rx_dv             (rx_dv),
    .i_rx_byte           (rx_byte),
    .o_thunder_packet_dv (dv),
    .o_thunder_year      (year),
    .o_thunder_month     (month),
    .o_thunder_day       (day),
    .o_thunder_hour      (hour),
    .o_thunder_minutes   (minutes),
    .o_thunder_seconds   (seconds),
    .o_thunder_flags     (flags),
    .o_frame_err         (err)
`ifdef TSIP_DEC_STATS_EN
    ,
    .o_good_count        (good_count),
    .o_err_count         (err_count)
`endif
  );

  int total = 0;
  int bad = 0;
  int dv_cnt = 0;
  int err_cnt = 0;
  int m_good = 0;
  int m_err = 0;
  logic [7:0]  pl[$];
  logic [15:0] m_year = 16'h0000;
  logic [7:0]  m_month = 8'h00, m_day = 8'h00, m_hour = 8'h00;
  logic [7:0]  m_min = 8'h00, m_sec = 8'h00, m_flags = 8'h00;

  always @(negedge clk) begin
    if (dv === 1'b1) dv_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_byte = 8'($urandom);
  endtask

  task automatic send_body();
    foreach (pl[i]) begin
      send_byte(pl[i]);
      if (pl[i] == 8'h10) send_byte(8'h10);
    end
    send_byte(8'h10);
    send_byte(8'h03);
  endtask

  task automatic build(input logic [7:0] sub, input logic [7:0] flg, input logic [7:0] sec,
                       input logic [7:0] mn, input logic [7:0] hr, input logic [7:0] dy,
                       input logic [7:0] mo, input logic [15:0] yr, input int len);
    pl.delete();
    pl.push_back(sub);
    for (int i = 1; i <= 8; i++) pl.push_back(8'($urandom));
    pl.push_back(flg);
    pl.push_back(sec);
    pl.push_back(mn);
    pl.push_back(hr);
    pl.push_back(dy);
    pl.push_back(mo);
    pl.push_back(yr[15:8]);
    pl.push_back(yr[7:0]);
    if (len == 16) void'(pl.pop_back());
    if (len == 18) pl.push_back(8'($urandom));
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "/year"}, 32'(year), 32'(m_year));
    chk({tag, "/month"}, 32'(month), 32'(m_month));
    chk({tag, "/day"}, 32'(day), 32'(m_day));
    chk({tag, "/hour"}, 32'(hour), 32'(m_hour));
    chk({tag, "/min"}, 32'(minutes), 32'(m_min));
    chk({tag, "/sec"}, 32'(seconds), 32'(m_sec));
    chk({tag, "/flags"}, 32'(flags), 32'(m_flags));
`ifdef TSIP_DEC_STATS_EN
    chk({tag, "/good_count"}, 32'(good_count), 32'(m_good[7:0]));
    chk({tag, "/err_count"}, 32'(err_count), 32'(m_err[7:0]));
`endif
  endtask

  // Sends the current payload plus DLE ETX and checks the frame outcome against the model.
  task automatic run_body(input string tag, input logic [7:0] id);
    bit exp_ok, exp_bad;
    int dv0, err0;
    exp_ok  = (id == 8'h8F) && (pl.size() == 17) && (pl[0] == 8'hAB);
    exp_bad = (id == 8'h8F) && !exp_ok;
    dv0  = dv_cnt;
    err0 = err_cnt;
    send_body();
    chk({tag, "/dv_latency"}, 32'(dv), 32'(exp_ok));
    chk({tag, "/err_latency"}, 32'(err), 32'(exp_bad));
    repeat (3) @(negedge clk);
    chk({tag, "/dv_pulses"}, 32'(dv_cnt - dv0), 32'(exp_ok));
    chk({tag, "/err_pulses"}, 32'(err_cnt - err0), 32'(exp_bad));
    if (exp_ok) begin
      m_sec   = pl[10];
      m_min   = pl[11];
      m_hour  = pl[12];
      m_day   = pl[13];
      m_month = pl[14];
      m_year  = {pl[15], pl[16]};
      m_flags = pl[9];
      m_good++;
    end
    if (exp_bad) m_err++;
    chk_outputs(tag);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] id);
    send_byte(8'h10);
    send_byte(id);
    run_body(tag, id);
  endtask

  task automatic spec_payload();
    pl = '{8'hAB, 8'h00, 8'h01, 8'h51, 8'h80, 8'h08, 8'h2C, 8'h00, 8'h12,
           8'h03, 8'h38, 8'h22, 8'h0C, 8'h0F, 8'h06, 8'h07, 8'hE8};
  endtask

  initial begin
    int k;
    int e0;
    int d0;
    bit seen;
    logic [7:0] id;
    int len;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset/dv", 32'(dv), 32'd0);
    chk("reset/err", 32'(err), 32'd0);
    chk_outputs("reset");

    spec_payload();
    run_frame("valid", 8'h8F);
    chk("valid/year_const", 32'(year), 32'h07E8);
    chk("valid/sec_const", 32'(seconds), 32'd56);

    spec_payload();
    pl[10] = 8'h10;
    run_frame("stuffed_sec", 8'h8F);

    build(8'hAC, 8'h55, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 16'd2030, 17);
    run_frame("bad_subcode", 8'h8F);
    build(8'hAB, 8'h55, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 16'd2030, 16);
    run_frame("short16", 8'h8F);
    build(8'hAB, 8'h55, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 16'd2030, 18);
    run_frame("long18", 8'h8F);
    build(8'hAB, 8'h55, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 16'd2030, 17);
    run_frame("other_id", 8'h41);

    // Resync: a DLE followed by a non-ETX byte opens a new frame with that byte as ID.
    send_byte(8'h10);
    send_byte(8'h8F);
    send_byte(8'hAB);
    send_byte(8'h05);
    send_byte(8'h10);
    send_byte(8'h8F);
    chk("resync/err_pulse", 32'(err), 32'd1);
    m_err++;
    @(negedge clk);
    build(8'hAB, 8'h07, 8'd9, 8'd8, 8'd7, 8'd6, 8'd11, 16'd2027, 17);
    run_body("resync", 8'h8F);

    // Timeout: idle mid-payload until the abort fires.
    send_byte(8'h10);
    send_byte(8'h8F);
    send_byte(8'hAB);
    send_byte(8'h01);
    send_byte(8'h02);
    e0 = err_cnt;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 70) begin
      @(negedge clk);
      k++;
      if (err === 1'b1) seen = 1'b1;
    end
    chk("timeout/cycles", 32'(k), 32'd50);
    repeat (3) @(negedge clk);
    chk("timeout/err_pulses", 32'(err_cnt - e0), 32'd1);
    m_err++;
    chk_outputs("timeout");
    spec_payload();
    run_frame("after_timeout", 8'h8F);

    // Reset mid-packet: no residual state, tail bytes must not decode.
    spec_payload();
    send_byte(8'h10);
    send_byte(8'h8F);
    for (int i = 0; i < 6; i++) send_byte(pl[i]);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_year = 16'h0000; m_month = 8'h00; m_day = 8'h00; m_hour = 8'h00;
    m_min = 8'h00; m_sec = 8'h00; m_flags = 8'h00; m_good = 0; m_err = 0;
    chk_outputs("midreset");
    d0 = dv_cnt;
    e0 = err_cnt;
    for (int i = 6; i < 17; i++) send_byte(pl[i]);
    send_byte(8'h10);
    send_byte(8'h03);
    repeat (3) @(negedge clk);
    chk("midreset/dv_pulses", 32'(dv_cnt - d0), 32'd0);
    chk("midreset/err_pulses", 32'(err_cnt - e0), 32'd0);
    chk_outputs("midreset_tail");

    for (int n = 0; n < 24; n++) begin
      id = ($urandom_range(0, 3) == 0) ? 8'h41 : 8'h8F;
      case ($urandom_range(0, 5))
        0: len = 16;
        1: len = 18;
        default: len = 17;
      endcase
      build(($urandom_range(0, 4) == 0) ? 8'hAC : 8'hAB, 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), len);
      run_frame($sformatf("rand%0d", n), id);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
